// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the write-back stage: instruction codes,
// register ids, status codes and the destination decode.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RSP   = 4'h4;

   typedef enum logic [2:0] {
      SAOK = 3'd1,
      SHLT = 3'd2,
      SADR = 3'd3,
      SINS = 3'd4
   } stat_t;

   // IRRMOVQ doubles as cmovxx; an untaken move drops its destination.
   function automatic logic [3:0] dst_e_of(input logic [3:0] icode,
                                           input logic [3:0] rb,
                                           input logic cnd);
      logic [3:0] dst;
      dst = RNONE;
      case (icode)
         IRRMOVQ:                      dst = cnd ? rb : RNONE;
         IIRMOVQ, IOPQ:                dst = rb;
         IPUSHQ, IPOPQ, ICALL, IRET:   dst = RSP;
         default:                      dst = RNONE;
      endcase
      return dst;
   endfunction

   function automatic logic [3:0] dst_m_of(input logic [3:0] icode,
                                           input logic [3:0] ra);
      logic [3:0] dst;
      dst = RNONE;
      if (icode == IMRMOVQ || icode == IPOPQ)
         dst = ra;
      return dst;
   endfunction

   function automatic stat_t norm_stat(input logic [2:0] s);
      stat_t st;
      case (s)
         3'd1:    st = SAOK;
         3'd2:    st = SHLT;
         3'd3:    st = SADR;
         default: st = SINS;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/regfile_core.sv
// Fifteen 64-bit architectural registers with E/M write ports (M wins on a
// shared destination) and three combinational read ports; id 0xF reads 0.
module regfile_core
   import y86_pkg::*;
#(
   parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_0200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_e,
   input  logic [3:0]  addr_e,
   input  logic [63:0] data_e,
   input  logic        we_m,
   input  logic [3:0]  addr_m,
   input  logic [63:0] data_m,
   input  logic [3:0]  addr_a,
   output logic [63:0] data_a,
   input  logic [3:0]  addr_b,
   output logic [63:0] data_b,
   input  logic [3:0]  addr_d,
   output logic [63:0] data_d
);

   logic [63:0] regs_reg [0:14];

   genvar gi;
   generate
      for (gi = 0; gi < 15; gi++) begin : g_reg
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               regs_reg[gi] <= (4'(gi) == RSP) ? STACK_INIT : 64'd0;
            else if (we_m && addr_m == 4'(gi))
               regs_reg[gi] <= data_m;
            else if (we_e && addr_e == 4'(gi))
               regs_reg[gi] <= data_e;
         end
      end
   endgenerate

   function automatic logic [63:0] rd(input logic [3:0] addr);
      logic [63:0] v;
      v = 64'd0;
      for (int i = 0; i < 15; i++)
         if (addr == 4'(i))
            v = regs_reg[i];
      return v;
   endfunction

   assign data_a = rd(addr_a);
   assign data_b = rd(addr_b);
   assign data_d = rd(addr_d);

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 SEQ write-back: destination decode, commit/halt gating, retire
// counter, latched status and optional same-cycle forwarding to decode.
module writeback_regfile
   import y86_pkg::*;
#(
   parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_0200,
   parameter bit          BYPASS     = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   input  logic [3:0]  icode,
   input  logic [3:0]  rA,
   input  logic [3:0]  rB,
   input  logic        cnd,
   input  logic [63:0] valE,
   input  logic [63:0] valM,
   input  logic [2:0]  stat_in,
   input  logic [3:0]  srcA,
   input  logic [3:0]  srcB,
   output logic [63:0] valA,
   output logic [63:0] valB,
   input  logic [3:0]  dbg_addr,
   output logic [63:0] dbg_data,
   output logic [63:0] retire_count,
   output logic        halted,
   output logic [2:0]  stat_out
);

   logic [3:0]  dst_e;
   logic [3:0]  dst_m;
   stat_t       stat_norm;
   logic        retire;
   logic        commit;
   logic [63:0] core_a;
   logic [63:0] core_b;
   logic        halted_reg;
   stat_t       stat_reg;
   logic [63:0] count_reg;

   assign dst_e     = dst_e_of(icode, rB, cnd);
   assign dst_m     = dst_m_of(icode, rA);
   assign stat_norm = norm_stat(stat_in);
   assign retire    = wb_valid && !halted_reg;
   assign commit    = retire && (stat_norm == SAOK);

   regfile_core #(
      .STACK_INIT (STACK_INIT)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .we_e   (commit && dst_e != RNONE),
      .addr_e (dst_e),
      .data_e (valE),
      .we_m   (commit && dst_m != RNONE),
      .addr_m (dst_m),
      .data_m (valM),
      .addr_a (srcA),
      .data_a (core_a),
      .addr_b (srcB),
      .data_b (core_b),
      .addr_d (dbg_addr),
      .data_d (dbg_data)
   );

   // Every retirement counts, including the one that halts the machine.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         halted_reg <= 1'b0;
         stat_reg   <= SAOK;
         count_reg  <= 64'd0;
      end else if (retire) begin
         count_reg <= count_reg + 64'd1;
         if (stat_norm != SAOK) begin
            halted_reg <= 1'b1;
            stat_reg   <= stat_norm;
         end
      end
   end

   assign retire_count = count_reg;
   assign halted       = halted_reg;
   assign stat_out     = stat_reg;

   function automatic logic [63:0] fwd(input logic [3:0] src,
                                       input logic [63:0] stored);
      logic [63:0] v;
      v = stored;
      if (commit && src != RNONE) begin
         if (dst_m == src)
            v = valM;
         else if (dst_e == src)
            v = valE;
      end
      return v;
   endfunction

   generate
      if (BYPASS) begin : g_bypass
         assign valA = fwd(srcA, core_a);
         assign valB = fwd(srcB, core_b);
      end else begin : g_direct
         assign valA = core_a;
         assign valB = core_b;
      end
   endgenerate

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: a BYPASS=0 instance under full check
// and a BYPASS=1 twin on the same inputs for the forwarding path.
module tb_writeback_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic [3:0]  icode, rA, rB;
   logic        cnd;
   logic [63:0] valE, valM;
   logic [2:0]  stat_in;
   logic [3:0]  srcA, srcB, dbg_addr;
   logic [63:0] valA, valB, dbg_data, retire_count;
   logic        halted;
   logic [2:0]  stat_out;
   logic [63:0] bp_valA, bp_valB, bp_dbg_data, bp_retire_count;
   logic        bp_halted;
   logic [2:0]  bp_stat_out;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   writeback_regfile #(.BYPASS(1'b0)) dut (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .icode(icode), .rA(rA), .rB(rB),
      .cnd(cnd), .valE(valE), .valM(valM), .stat_in(stat_in), .srcA(srcA),
      .srcB(srcB), .valA(valA), .valB(valB), .dbg_addr(dbg_addr),
      .dbg_data(dbg_data), .retire_count(retire_count), .halted(halted),
      .stat_out(stat_out)
   );

   writeback_regfile #(.BYPASS(1'b1)) dut_bp (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .icode(icode), .rA(rA), .rB(rB),
      .cnd(cnd), .valE(valE), .valM(valM), .stat_in(stat_in), .srcA(srcA),
      .srcB(srcB), .valA(bp_valA), .valB(bp_valB), .dbg_addr(dbg_addr),
      .dbg_data(bp_dbg_data), .retire_count(bp_retire_count), .halted(bp_halted),
      .stat_out(bp_stat_out)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic reg_chk(input logic [3:0] r, input logic [63:0] exp, input string tag);
      dbg_addr = r;
      #1;
      chk(tag, dbg_data, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic retire_op(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                            input logic c, input logic [63:0] e, input logic [63:0] m,
                            input logic [2:0] st);
      wb_valid = 1'b1; icode = ic; rA = ra; rB = rb; cnd = c;
      valE = e; valM = m; stat_in = st;
      step();
      wb_valid = 1'b0;
      $display("retire icode=%h rA=%h rB=%h cnd=%0d valE=%h valM=%h stat=%0d -> count=%0d halted=%0d",
               ic, ra, rb, c, e, m, st, retire_count, halted);
   endtask

   initial begin
      rst = 1'b1; wb_valid = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
      valE = '0; valM = '0; stat_in = 3'd1; srcA = 4'hF; srcB = 4'hF; dbg_addr = 4'h0;
      #12 rst = 1'b0;
      #1;

      // 1. reset state
      for (int r = 0; r < 16; r++)
         reg_chk(4'(r), (r == 4) ? 64'h200 : 64'h0, $sformatf("reset_reg%0d", r));
      chk("reset_halted", {63'd0, halted}, 64'd0);
      chk("reset_stat", {61'd0, stat_out}, 64'd1);
      chk("reset_count", retire_count, 64'd0);

      // 2. irmovq to reg2; bypass twin forwards before the edge
      srcA = 4'h2;
      wb_valid = 1'b1; icode = 4'h3; rA = 4'hF; rB = 4'h2; cnd = 1'b0;
      valE = 64'h1234; valM = 64'h0; stat_in = 3'd1;
      #1;
      chk("nobypass_valA_pre", valA, 64'h0);
      chk("bypass_valA_fwd", bp_valA, 64'h1234);
      step();
      wb_valid = 1'b0;
      $display("retire irmovq rB=2 valE=1234 -> count=%0d", retire_count);
      reg_chk(4'h2, 64'h1234, "irmovq_reg2");
      chk("irmovq_valA", valA, 64'h1234);
      chk("irmovq_count", retire_count, 64'd1);

      // 3. cmovxx not taken, then taken
      retire_op(4'h2, 4'h1, 4'h3, 1'b0, 64'h7, 64'h0, 3'd1);
      reg_chk(4'h3, 64'h0, "cmov_nt_reg3");
      chk("cmov_nt_count", retire_count, 64'd2);
      retire_op(4'h2, 4'h1, 4'h3, 1'b1, 64'h7, 64'h0, 3'd1);
      reg_chk(4'h3, 64'h7, "cmov_t_reg3");

      // 4. popq %rsp: M beats E; bypass twin forwards valM
      srcB = 4'h4;
      wb_valid = 1'b1; icode = 4'hB; rA = 4'h4; rB = 4'hF; cnd = 1'b0;
      valE = 64'h208; valM = 64'h55; stat_in = 3'd1;
      #1;
      chk("bypass_valB_mprio", bp_valB, 64'h55);
      chk("nobypass_valB_pre", valB, 64'h200);
      step();
      wb_valid = 1'b0;
      $display("retire popq rA=4 valE=208 valM=55 -> count=%0d", retire_count);
      reg_chk(4'h4, 64'h55, "popq_rsp_mwins");
      retire_op(4'h5, 4'h5, 4'h6, 1'b0, 64'h99, 64'h9, 3'd1);
      reg_chk(4'h5, 64'h9, "mrmovq_reg5");
      reg_chk(4'h6, 64'h0, "mrmovq_no_rb");
      retire_op(4'h6, 4'h1, 4'h7, 1'b0, 64'hAA, 64'h0, 3'd1);
      reg_chk(4'h7, 64'hAA, "opq_reg7");
      chk("opq_count", retire_count, 64'd6);

      // 5. halt, then a frozen machine
      retire_op(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 3'd2);
      chk("halt_halted", {63'd0, halted}, 64'd1);
      chk("halt_stat", {61'd0, stat_out}, 64'd2);
      chk("halt_count", retire_count, 64'd7);
      retire_op(4'h3, 4'hF, 4'h2, 1'b0, 64'hDEAD, 64'h0, 3'd1);
      reg_chk(4'h2, 64'h1234, "after_halt_reg2");
      chk("after_halt_count", retire_count, 64'd7);
      chk("after_halt_stat", {61'd0, stat_out}, 64'd2);
      chk("bypass_after_halt_valA", bp_valA, 64'h1234);

      // 6. reset with a commit in flight
      wb_valid = 1'b1; icode = 4'h3; rB = 4'h2; valE = 64'hBEEF; stat_in = 3'd1;
      rst = 1'b1;
      #1;
      reg_chk(4'h2, 64'h0, "rst_async_reg2");
      reg_chk(4'h4, 64'h200, "rst_async_rsp");
      @(posedge clk);
      #4 rst = 1'b0;
      wb_valid = 1'b0;
      #1;
      reg_chk(4'h2, 64'h0, "rst_inflight_reg2");
      chk("rst_count", retire_count, 64'd0);
      chk("rst_halted", {63'd0, halted}, 64'd0);
      srcA = 4'hF;
      #1;
      chk("rnone_valA", valA, 64'h0);

      // out-of-range status is treated as INS
      retire_op(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 3'd7);
      chk("badstat_stat", {61'd0, stat_out}, 64'd4);
      chk("badstat_halted", {63'd0, halted}, 64'd1);
      chk("badstat_count", retire_count, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed no finish expected finish before 20000");
      $fatal(1, "timeout");
   end

endmodule
